// File: rtl/alu_seq_if.sv
// Op-code encodings and the valid/ready interface shared by the sequential ALU
// and whoever drives it (decode stage on the input side, writeback on the output side).
package alu_seq_pkg;
  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_SUB     = 5'd1;
  localparam logic [4:0] ALU_AND     = 5'd2;
  localparam logic [4:0] ALU_OR      = 5'd3;
  localparam logic [4:0] ALU_XOR     = 5'd4;
  localparam logic [4:0] ALU_LSHIFT  = 5'd5;
  localparam logic [4:0] ALU_LRSHIFT = 5'd6;
  localparam logic [4:0] ALU_ARSHIFT = 5'd7;
  localparam logic [4:0] ALU_MUL     = 5'd8;
  localparam logic [4:0] ALU_DIV     = 5'd9;
  localparam logic [4:0] ALU_DIVU    = 5'd10;
  localparam logic [4:0] ALU_REM     = 5'd11;
  localparam logic [4:0] ALU_REMU    = 5'd12;
  localparam logic [4:0] ALU_SUBU    = 5'd13;
endpackage

interface alu_seq_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             illegal_op;

  modport master (
    output flush, in_valid, alu_op, r1, r2, out_ready,
    input  in_ready, out_valid, res, zero, illegal_op
  );

  modport slave (
    input  flush, in_valid, alu_op, r1, r2, out_ready,
    output in_ready, out_valid, res, zero, illegal_op
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide, valid/ready handshakes on both sides.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit MUL_ITER = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int               CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_START = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_workA;
  logic [WIDTH-1:0] r_workB;
  logic [WIDTH-1:0] r_workC;
  logic             r_isMul;
  logic             r_wantRem;
  logic             r_negQ;
  logic             r_negR;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_illegal;

  logic             w_inReady;
  logic             w_accept;
  logic             w_isDiv;
  logic             w_isSignedDiv;
  logic             w_divZero;
  logic             w_divOvf;
  logic             w_mulIter;
  logic             w_iterOp;
  logic [CW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_fastRes;
  logic             w_fastIllegal;
  logic [WIDTH-1:0] w_mulAcc;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_divRem;
  logic [WIDTH-1:0] w_divQuo;
  logic [WIDTH-1:0] w_iterRes;

  // Divides by zero and the one signed-overflow case finish in a single cycle.
  always_comb begin
    w_isDiv       = (bus.alu_op == ALU_DIV) || (bus.alu_op == ALU_DIVU) ||
                    (bus.alu_op == ALU_REM) || (bus.alu_op == ALU_REMU);
    w_isSignedDiv = (bus.alu_op == ALU_DIV) || (bus.alu_op == ALU_REM);
    w_divZero     = w_isDiv && (bus.r2 == '0);
    w_divOvf      = w_isSignedDiv && (bus.r1 == MIN_NEG) && (bus.r2 == '1);
    w_mulIter     = MUL_ITER && (bus.alu_op == ALU_MUL);
    w_iterOp      = w_mulIter || (w_isDiv && !w_divZero && !w_divOvf);
    w_shamt       = bus.r2[CW-1:0];
    w_absA        = (w_isSignedDiv && bus.r1[WIDTH-1]) ? -bus.r1 : bus.r1;
    w_absB        = (w_isSignedDiv && bus.r2[WIDTH-1]) ? -bus.r2 : bus.r2;
  end

  always_comb begin
    w_fastRes     = '0;
    w_fastIllegal = 1'b0;
    case (bus.alu_op)
      ALU_ADD:            w_fastRes = bus.r1 + bus.r2;
      ALU_SUB, ALU_SUBU:  w_fastRes = bus.r1 - bus.r2;
      ALU_AND:            w_fastRes = bus.r1 & bus.r2;
      ALU_OR:             w_fastRes = bus.r1 | bus.r2;
      ALU_XOR:            w_fastRes = bus.r1 ^ bus.r2;
      ALU_LSHIFT:         w_fastRes = bus.r1 << w_shamt;
      ALU_LRSHIFT:        w_fastRes = bus.r1 >> w_shamt;
      ALU_ARSHIFT:        w_fastRes = $signed(bus.r1) >>> w_shamt;
      ALU_MUL:            w_fastRes = MUL_ITER ? '0 : bus.r1 * bus.r2;
      ALU_DIV, ALU_DIVU: begin
        w_fastRes     = w_divOvf ? bus.r1 : '1;
        w_fastIllegal = w_divZero;
      end
      ALU_REM, ALU_REMU: begin
        w_fastRes     = w_divOvf ? '0 : bus.r1;
        w_fastIllegal = w_divZero;
      end
      default:            w_fastIllegal = 1'b1;
    endcase
  end

  // workA = accumulator / partial remainder, workB = multiplier / quotient,
  // workC = multiplicand / divisor magnitude.
  always_comb begin
    w_mulAcc = r_workA + (r_workB[0] ? r_workC : '0);
    w_trial  = {r_workA, r_workB[WIDTH-1]};
    w_diff   = w_trial - {1'b0, r_workC};
    w_fits   = !w_diff[WIDTH];
    w_divRem = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_divQuo = {r_workB[WIDTH-2:0], w_fits};
    if (r_isMul)        w_iterRes = w_mulAcc;
    else if (r_wantRem) w_iterRes = r_negR ? -w_divRem : w_divRem;
    else                w_iterRes = r_negQ ? -w_divQuo : w_divQuo;
  end

  always_comb begin
    w_inReady   = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    w_accept    = bus.in_valid && w_inReady && !bus.flush;
    w_nextState = r_state;
    if (bus.flush)                              w_nextState = IDLE;
    else if (w_accept)                          w_nextState = w_iterOp ? BUSY : DONE;
    else if ((r_state == BUSY) && (r_count == '0)) w_nextState = DONE;
    else if ((r_state == DONE) && bus.out_ready)   w_nextState = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_workA   <= '0;
      r_workB   <= '0;
      r_workC   <= '0;
      r_isMul   <= 1'b0;
      r_wantRem <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_res     <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      if (w_iterOp) begin
        r_count   <= CNT_START;
        r_isMul   <= w_mulIter;
        r_wantRem <= (bus.alu_op == ALU_REM) || (bus.alu_op == ALU_REMU);
        r_negQ    <= w_isSignedDiv && (bus.r1[WIDTH-1] ^ bus.r2[WIDTH-1]);
        r_negR    <= w_isSignedDiv && bus.r1[WIDTH-1];
        r_workA   <= '0;
        r_workB   <= w_mulIter ? bus.r2 : w_absA;
        r_workC   <= w_mulIter ? bus.r1 : w_absB;
      end else begin
        r_res     <= w_fastRes;
        r_zero    <= (w_fastRes == '0);
        r_illegal <= w_fastIllegal;
      end
    end else if ((r_state == BUSY) && !bus.flush) begin
      r_count <= r_count - CW'(1);
      if (r_isMul) begin
        r_workA <= w_mulAcc;
        r_workB <= r_workB >> 1;
        r_workC <= r_workC << 1;
      end else begin
        r_workA <= w_divRem;
        r_workB <= w_divQuo;
      end
      if (r_count == '0) begin
        r_res     <= w_iterRes;
        r_zero    <= (w_iterRes == '0);
        r_illegal <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = (r_state == DONE);
  assign bus.res        = r_res;
  assign bus.zero       = r_zero;
  assign bus.illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: a 32-bit instance with iterative multiply
// and a 16-bit instance with single-cycle multiply.
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   startCycle;
  logic sawValid;
  exp_t scoreboard[$];

  alu_seq_if #(.WIDTH(32)) bus32();
  alu_seq_if #(.WIDTH(16)) bus16();

  alu_seq #(.WIDTH(32), .MUL_ITER(1'b1)) u32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_seq #(.WIDTH(16), .MUL_ITER(1'b0)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one op at a negedge, returns at the negedge after the accepting edge
  // with operands scrambled so late input changes would show up as wrong results.
  task automatic driveOp(input int which, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (which == 0) begin
      checkVal("in_ready32", bus32.in_ready, 32'd1);
      bus32.in_valid = 1'b1;
      bus32.alu_op   = op;
      bus32.r1       = a;
      bus32.r2       = b;
    end else begin
      checkVal("in_ready16", bus16.in_ready, 32'd1);
      bus16.in_valid = 1'b1;
      bus16.alu_op   = op;
      bus16.r1       = a[15:0];
      bus16.r2       = b[15:0];
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
    bus32.r1       = $urandom();
    bus32.r2       = $urandom();
    bus16.r1       = 16'($urandom());
    bus16.r2       = 16'($urandom());
  endtask

  task automatic applyStimulus(input int which, input logic [4:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input logic expIll, input int expLat);
    exp_t e;
    e.res  = expRes;
    e.zero = (expRes == 32'd0);
    e.ill  = expIll;
    e.lat  = expLat;
    scoreboard.push_back(e);
    driveOp(which, op, a, b);
  endtask

  task automatic checkOutput(input int which, input string tag);
    exp_t        e;
    int          lat;
    logic        v;
    logic [31:0] r;
    logic        z;
    logic        il;
    lat = 1;
    v   = (which == 0) ? bus32.out_valid : bus16.out_valid;
    while (!v && lat < 100) begin
      @(negedge clk);
      lat++;
      v = (which == 0) ? bus32.out_valid : bus16.out_valid;
    end
    r  = (which == 0) ? bus32.res : {16'h0, bus16.res};
    z  = (which == 0) ? bus32.zero : bus16.zero;
    il = (which == 0) ? bus32.illegal_op : bus16.illegal_op;
    checkVal($sformatf("%s.pending", tag), (scoreboard.size() > 0), 32'd1);
    e = scoreboard.pop_front();
    checkVal($sformatf("%s.valid", tag), v, 32'd1);
    checkVal($sformatf("%s.latency", tag), lat, e.lat);
    checkVal($sformatf("%s.res", tag), r, e.res);
    checkVal($sformatf("%s.zero", tag), z, e.zero);
    checkVal($sformatf("%s.illegal", tag), il, e.ill);
  endtask

  initial begin
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.alu_op = ALU_ADD;
    bus32.r1 = '0; bus32.r2 = '0; bus32.out_ready = 1'b1;
    bus16.flush = 1'b0; bus16.in_valid = 1'b0; bus16.alu_op = ALU_ADD;
    bus16.r1 = '0; bus16.r2 = '0; bus16.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("reset.out_valid", bus32.out_valid, 32'd0);
    checkVal("reset.res", bus32.res, 32'd0);
    checkVal("reset.zero", bus32.zero, 32'd1);
    checkVal("reset.illegal", bus32.illegal_op, 32'd0);
    checkVal("reset.in_ready", bus32.in_ready, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, ALU_ADD, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 1);
    checkOutput(0, "add");
    applyStimulus(0, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b0, 1);
    checkOutput(0, "sub_zero");
    applyStimulus(0, ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33);
    checkOutput(0, "div_neg");
    applyStimulus(0, ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33);
    checkOutput(0, "rem_neg");
    applyStimulus(0, ALU_DIVU, 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF, 1'b0, 33);
    checkOutput(0, "divu");
    applyStimulus(0, ALU_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 33);
    checkOutput(0, "div_negdivisor");
    applyStimulus(0, ALU_REM, 32'd100, 32'hFFFFFFF9, 32'd2, 1'b0, 33);
    checkOutput(0, "rem_negdivisor");
    applyStimulus(0, ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    checkOutput(0, "remu");
    applyStimulus(0, ALU_DIV, 32'h1234, 32'd0, 32'hFFFFFFFF, 1'b1, 1);
    checkOutput(0, "div_by_zero");
    applyStimulus(0, ALU_REMU, 32'h1234, 32'd0, 32'h1234, 1'b1, 1);
    checkOutput(0, "remu_by_zero");
    applyStimulus(0, ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    checkOutput(0, "div_ovf");
    applyStimulus(0, ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1);
    checkOutput(0, "rem_ovf");
    applyStimulus(0, ALU_MUL, 32'h10000, 32'h10000, 32'd0, 1'b0, 33);
    checkOutput(0, "mul_wrap");
    applyStimulus(0, ALU_MUL, 32'd12345, 32'd6789, 32'h04FED79D, 1'b0, 33);
    checkOutput(0, "mul");

    // Result must stay put while writeback stalls.
    applyStimulus(0, ALU_MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, 33);
    bus32.out_ready = 1'b0;
    checkOutput(0, "mul_neg_hold");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkVal("hold.valid", bus32.out_valid, 32'd1);
      checkVal("hold.res", bus32.res, 32'hFFFFFFF1);
      checkVal("hold.in_ready", bus32.in_ready, 32'd0);
    end
    bus32.out_ready = 1'b1;
    @(negedge clk);
    checkVal("hold.release", bus32.out_valid, 32'd0);

    startCycle = cycle;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, ALU_ADD, 32'(100 * (k + 1)), 32'(k), 32'(100 * (k + 1) + k), 1'b0, 1);
      checkOutput(0, $sformatf("stream%0d", k));
    end
    checkVal("stream.cycles", cycle - startCycle, 32'd4);

    driveOp(0, ALU_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus32.flush = 1'b1;
    @(negedge clk);
    bus32.flush = 1'b0;
    checkVal("flush.out_valid", bus32.out_valid, 32'd0);
    checkVal("flush.in_ready", bus32.in_ready, 32'd1);
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.out_valid) sawValid = 1'b1;
    end
    checkVal("flush.no_result", sawValid, 32'd0);

    bus32.flush = 1'b1;
    bus32.in_valid = 1'b1;
    bus32.alu_op = ALU_ADD;
    bus32.r1 = 32'd7;
    bus32.r2 = 32'd8;
    @(negedge clk);
    bus32.flush = 1'b0;
    bus32.in_valid = 1'b0;
    checkVal("flush_in.not_accepted", bus32.out_valid, 32'd0);

    driveOp(0, ALU_ADD, 32'd1, 32'd1);
    bus32.out_ready = 1'b0;
    checkVal("flush_done.valid", bus32.out_valid, 32'd1);
    bus32.flush = 1'b1;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    bus32.flush = 1'b0;
    checkVal("flush_done.dropped", bus32.out_valid, 32'd0);

    driveOp(0, ALU_DIVU, 32'd77, 32'd5);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkVal("midreset.out_valid", bus32.out_valid, 32'd0);
    checkVal("midreset.res", bus32.res, 32'd0);
    checkVal("midreset.zero", bus32.zero, 32'd1);
    checkVal("midreset.illegal", bus32.illegal_op, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.out_valid) sawValid = 1'b1;
    end
    checkVal("midreset.no_result", sawValid, 32'd0);

    applyStimulus(0, ALU_ARSHIFT, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1);
    checkOutput(0, "arshift");
    applyStimulus(0, ALU_LRSHIFT, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1);
    checkOutput(0, "lrshift");
    applyStimulus(0, ALU_LSHIFT, 32'd1, 32'd31, 32'h80000000, 1'b0, 1);
    checkOutput(0, "lshift");
    applyStimulus(0, ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1);
    checkOutput(0, "and");
    applyStimulus(0, ALU_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1);
    checkOutput(0, "or");
    applyStimulus(0, ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1);
    checkOutput(0, "xor");
    applyStimulus(0, ALU_SUBU, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1);
    checkOutput(0, "subu");
    applyStimulus(0, 5'd31, 32'd3, 32'd5, 32'd0, 1'b1, 1);
    checkOutput(0, "undefined_op");

    applyStimulus(1, ALU_ADD, 32'd5, 32'hFFF9, 32'hFFFE, 1'b0, 1);
    checkOutput(1, "w16.add");
    applyStimulus(1, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b0, 1);
    checkOutput(1, "w16.sub_zero");
    applyStimulus(1, ALU_DIV, 32'hFFF9, 32'd2, 32'hFFFD, 1'b0, 17);
    checkOutput(1, "w16.div_neg");
    applyStimulus(1, ALU_REM, 32'hFFF9, 32'd2, 32'hFFFF, 1'b0, 17);
    checkOutput(1, "w16.rem_neg");
    applyStimulus(1, ALU_DIVU, 32'hFFFE, 32'd2, 32'h7FFF, 1'b0, 17);
    checkOutput(1, "w16.divu");
    applyStimulus(1, ALU_DIV, 32'h1234, 32'd0, 32'hFFFF, 1'b1, 1);
    checkOutput(1, "w16.div_by_zero");
    applyStimulus(1, ALU_REMU, 32'h1234, 32'd0, 32'h1234, 1'b1, 1);
    checkOutput(1, "w16.remu_by_zero");
    applyStimulus(1, ALU_DIV, 32'h8000, 32'hFFFF, 32'h8000, 1'b0, 1);
    checkOutput(1, "w16.div_ovf");
    applyStimulus(1, ALU_MUL, 32'h100, 32'h100, 32'd0, 1'b0, 1);
    checkOutput(1, "w16.mul_wrap");
    applyStimulus(1, ALU_MUL, 32'h123, 32'h45, 32'h4E6F, 1'b0, 1);
    checkOutput(1, "w16.mul");
    applyStimulus(1, ALU_ARSHIFT, 32'h8000, 32'h24, 32'hF800, 1'b0, 1);
    checkOutput(1, "w16.arshift");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
